// File: rtl/rem5_arbiter.sv
// rem5_arbiter: shares one serial divisible-by-5 detector among NUM_REQ requesters (define REM_ARB_FIXED_PRIO_EN for fixed-priority grants)
module rem5_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_W     = 16,
    parameter int RESULT_LAT = 2
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic [NUM_REQ-1:0]        rsp_valid,
    output logic                      rsp_div,
    output logic                      ser_valid,
    output logic                      ser_bit,
    input  logic                      ser_div_flag,
    output logic                      busy
);
    localparam int IW   = $clog2(NUM_REQ);
    localparam int CMAX = DATA_W > RESULT_LAT ? DATA_W : RESULT_LAT;
    localparam int CW   = $clog2(CMAX + 1);

    typedef enum logic [1:0] {IDLE, SHIFT, WAIT, RESP} state_t;

    state_t            state, state_nxt;
    logic [DATA_W-1:0] shreg, grant_word;
    logic [CW-1:0]     cnt;
    logic [IW-1:0]     owner, grant_idx, start, idx;
    logic              found, last;

`ifdef REM_ARB_FIXED_PRIO_EN
    assign start = '0;
`else
    logic [IW-1:0] rr_ptr;
    assign start = rr_ptr;

    // round-robin pointer moves just past the requester that was accepted
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            rr_ptr <= '0;
        else if (state == IDLE && found)
            rr_ptr <= (grant_idx == IW'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
    end
`endif

    // pick the first requesting index at or after start, wrapping once
    always_comb begin
        found      = 1'b0;
        grant_idx  = '0;
        grant_word = '0;
        idx        = start;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!found && req_valid[idx]) begin
                found     = 1'b1;
                grant_idx = idx;
            end
            idx = (idx == IW'(NUM_REQ - 1)) ? '0 : idx + 1'b1;
        end
        for (int k = 0; k < NUM_REQ; k++)
            if (grant_idx == IW'(k)) grant_word = req_data[k*DATA_W +: DATA_W];
    end

    assign last = (state == SHIFT) ? cnt == CW'(DATA_W - 1) : cnt == CW'(RESULT_LAT - 1);

    // state register; reset aborts any word in flight
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // next state and all handshake/serial outputs decoded from state
    always_comb begin
        state_nxt = state;
        req_ready = '0;
        rsp_valid = '0;
        ser_valid = 1'b0;
        ser_bit   = 1'b0;
        busy      = state != IDLE;
        case (state)
            IDLE: begin
                req_ready = found ? NUM_REQ'(1) << grant_idx : '0;
                state_nxt = found ? SHIFT : IDLE;
            end
            SHIFT: begin
                ser_valid = 1'b1;
                ser_bit   = shreg[DATA_W-1];
                state_nxt = last ? WAIT : SHIFT;
            end
            WAIT:    state_nxt = last ? RESP : WAIT;
            RESP: begin
                rsp_valid = NUM_REQ'(1) << owner;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // word capture, MSb-first shifting, phase counter and result sampling
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            shreg   <= '0;
            cnt     <= '0;
            owner   <= '0;
            rsp_div <= 1'b0;
        end else begin
            case (state)
                IDLE: if (found) begin
                    shreg <= grant_word;
                    owner <= grant_idx;
                    cnt   <= '0;
                end
                SHIFT: begin
                    shreg <= shreg << 1;
                    cnt   <= last ? '0 : cnt + 1'b1;
                end
                WAIT: begin
                    cnt <= last ? '0 : cnt + 1'b1;
                    if (last) rsp_div <= ser_div_flag;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_rem5_arbiter.sv
// tb_rem5_arbiter: directed plus random checks of rem5_arbiter against a word-level reference model
module tb_rem5_arbiter;
    localparam int NUM_REQ    = 4;
    localparam int DATA_W     = 8;
    localparam int RESULT_LAT = 2;
    localparam int LAT        = DATA_W + RESULT_LAT + 1;
`ifdef REM_ARB_FIXED_PRIO_EN
    localparam int FAIR_EXP = 0;
`else
    localparam int FAIR_EXP = 3;
`endif

    logic                      clk = 1'b0;
    logic                      reset;
    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ*DATA_W-1:0] req_data;
    logic [NUM_REQ-1:0]        req_ready, rsp_valid;
    logic                      rsp_div, ser_valid, ser_bit, ser_div_flag, busy;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    rem5_arbiter #(.NUM_REQ(NUM_REQ), .DATA_W(DATA_W), .RESULT_LAT(RESULT_LAT)) dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_data(req_data),
        .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_div(rsp_div),
        .ser_valid(ser_valid), .ser_bit(ser_bit), .ser_div_flag(ser_div_flag), .busy(busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // serial mod-5 detector stand-in: remainder restarts while valid is low
    int det_rem;
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            det_rem      <= 0;
            ser_div_flag <= 1'b0;
        end else if (ser_valid) begin
            det_rem      <= (det_rem * 2 + int'(ser_bit)) % 5;
            ser_div_flag <= ((det_rem * 2 + int'(ser_bit)) % 5) == 0;
        end else begin
            det_rem <= 0;
        end
    end

    // word-level reference: arbitration rule, per-word expectations, gap rule
    typedef struct {int g; logic [DATA_W-1:0] w; int c;} ent_t;
    ent_t              q[$];
    ent_t              e;
    int                glog[$], alog[$], dlog[$];
    int                m_ptr, low_run, nb, og, last_owner, last_lat, rsp_cnt;
    logic [DATA_W-1:0] sv, last_bits;
    logic              seen, last_div;
    logic [NUM_REQ-1:0] exp_rdy;

    always @(negedge clk) begin
        if (reset) begin
            q.delete();
            m_ptr   = 0;
            seen    = 1'b0;
            low_run = 0;
            nb      = 0;
            sv      = '0;
        end else begin
            check("busy", busy, q.size() != 0);
            exp_rdy = '0;
            if (!busy)
                for (int k = 0; k < NUM_REQ; k++)
                    if (exp_rdy == 0 && req_valid[(m_ptr + k) % NUM_REQ]) exp_rdy[(m_ptr + k) % NUM_REQ] = 1'b1;
            check("req_ready", req_ready, exp_rdy);
            if (ser_valid) begin
                if (seen && low_run > 0) check("gap_len", low_run >= RESULT_LAT + 1, 1);
                seen    = 1'b1;
                low_run = 0;
                sv      = (sv << 1) | DATA_W'(ser_bit);
                nb++;
            end else begin
                check("ser_bit_idle", ser_bit, 0);
                low_run++;
            end
            if ((req_ready & req_valid) != 0) begin
                og = 0;
                for (int k = 0; k < NUM_REQ; k++) if (req_ready[k]) og = k;
                q.push_back('{og, req_data[og*DATA_W +: DATA_W], cyc});
                glog.push_back(og);
                alog.push_back(cyc);
`ifndef REM_ARB_FIXED_PRIO_EN
                for (int k = 0; k < NUM_REQ; k++) if (exp_rdy[k]) m_ptr = (k + 1) % NUM_REQ;
`endif
                sv = '0;
                nb = 0;
            end
            if (rsp_valid != 0) begin
                if (q.size() == 0) begin
                    check("rsp_spurious", rsp_valid, 0);
                end else begin
                    e = q.pop_front();
                    og = 0;
                    for (int k = 0; k < NUM_REQ; k++) if (rsp_valid[k]) og = k;
                    check("rsp_onehot", rsp_valid, 32'(1) << e.g);
                    check("rsp_div", rsp_div, (e.w % 5) == 0);
                    check("rsp_lat", cyc - e.c, LAT);
                    check("ser_word", sv, e.w);
                    check("ser_nbits", nb, DATA_W);
                    last_owner = og;
                    last_div   = rsp_div;
                    last_lat   = cyc - e.c;
                    last_bits  = sv;
                    dlog.push_back(int'(rsp_div));
                    rsp_cnt++;
                end
            end
        end
    end

    task automatic put(int i, logic [DATA_W-1:0] w);
        req_valid[i] = 1'b1;
        req_data[i*DATA_W +: DATA_W] = w;
    endtask

    task automatic drain(int bound);
        int n = 0;
        logic [NUM_REQ-1:0] acc;
        while ((req_valid != 0 || busy || q.size() != 0) && n < bound) begin
            @(negedge clk);
            acc = req_ready & req_valid;
            @(posedge clk);
            #1 req_valid = req_valid & ~acc;
            n++;
        end
        check("drain_timeout", n < bound, 1);
    endtask

    task automatic single(string tag, int i, logic [DATA_W-1:0] w, logic div);
        int rc = rsp_cnt;
        put(i, w);
        drain(100);
        check({tag, "_count"}, rsp_cnt - rc, 1);
        check({tag, "_owner"}, last_owner, i);
        check({tag, "_div"}, last_div, div);
        check({tag, "_lat"}, last_lat, LAT);
    endtask

    initial begin
        int n, rc;
        int cw[4] = '{5, 6, 10, 11};
        logic [NUM_REQ-1:0] mask;
        reset = 1'b1;
        req_valid = '0;
        req_data = '0;
        rsp_cnt = 0;
        #2;
        check("rst_req_ready", req_ready, 0);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_rsp_div", rsp_div, 0);
        check("rst_ser_valid", ser_valid, 0);
        check("rst_ser_bit", ser_bit, 0);
        check("rst_busy", busy, 0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;

        single("w0a", 0, 8'h0A, 1'b1);
        check("w0a_bits", last_bits, 8'h0A);
        single("w07", 2, 8'h07, 1'b0);
        single("w00", 1, 8'h00, 1'b1);
        single("wff", 3, 8'hFF, 1'b1);

        glog.delete(); alog.delete(); dlog.delete();
        for (int i = 0; i < 4; i++) put(i, DATA_W'(cw[i]));
        drain(200);
        check("cont_n", glog.size(), 4);
        for (int i = 0; i < 4; i++) begin
            check("cont_grant", glog[i], i);
            check("cont_div", dlog[i], (cw[i] % 5) == 0);
            if (i > 0) check("cont_period", alog[i] - alog[i-1], LAT + 1);
        end

        single("fair_pre", 1, 8'h33, 1'b0);
        glog.delete();
        put(0, 8'h12);
        put(3, 8'h34);
        drain(100);
        check("fair_first", glog[0], FAIR_EXP);
        check("fair_second", glog[1], 3 - FAIR_EXP);

        put(0, 8'h33);
        n = 0;
        @(negedge clk);
        while (!req_ready[0] && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("mid_accept", req_ready[0], 1);
        @(posedge clk);
        #1 req_valid = '0;
        repeat (3) @(posedge clk);
        #2 check("mid_4th_bit", ser_valid, 1);
        rc = rsp_cnt;
        reset = 1'b1;
        #1;
        check("mid_ser_valid", ser_valid, 0);
        check("mid_busy", busy, 0);
        check("mid_rsp_valid", rsp_valid, 0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        repeat (20) @(posedge clk);
        #1 check("mid_no_rsp", rsp_cnt - rc, 0);
        single("after_rst", 0, 8'h0F, 1'b1);

        repeat (40) begin
            mask = NUM_REQ'($urandom_range(1, (1 << NUM_REQ) - 1));
            for (int i = 0; i < NUM_REQ; i++)
                if (mask[i])
                    put(i, ($urandom_range(0, 3) == 0) ? ($urandom_range(0, 1) == 0 ? '0 : '1) : DATA_W'($urandom));
            drain(300);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
